axil_reg_slave: RTL and testbench
=================================

AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width (4 regs x 4 bytes).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 ACLK  in  1  sole clock, all logic on rising edge.
REQ-005 ARESET  in  1  synchronous active-high reset.
REQ-006 S_AXI_AWADDR in 4, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write address channel.
REQ-007 S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write data channel.
REQ-008 S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response channel.
REQ-009 S_AXI_ARADDR in 4, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address channel.
REQ-010 S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data channel.
REQ-011 regs_o  out  128  live register contents, reg N at bits [32N+31:32N].

Function
REQ-012 SHALL implement AXI4-Lite responder with 4 x 32-bit R/W registers; reg index = ADDR[3:2].
REQ-013 Write FSM SHALL have states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
REQ-014 AWREADY SHALL be high only in W_IDLE and W_HAVE_W; WREADY only in W_IDLE and W_HAVE_AW.
REQ-015 W_IDLE: AW only -> latch addr, W_HAVE_AW; W only -> latch data/strb, W_HAVE_W; both same cycle -> commit, W_RESP.
REQ-016 W_HAVE_AW on W handshake, or W_HAVE_W on AW handshake -> commit, W_RESP.
REQ-017 Commit SHALL update only bytes with WSTRB bit set; register visible on regs_o the cycle after commit.
REQ-018 BVALID SHALL assert the cycle after commit, hold with stable BRESP until BREADY; BVALID&BREADY -> W_IDLE.
REQ-019 Read FSM SHALL have states R_IDLE, R_DATA; ARREADY high only in R_IDLE.
REQ-020 AR handshake SHALL register RDATA from addressed reg, RVALID next cycle, RDATA/RRESP stable until RREADY; RVALID&RREADY -> R_IDLE.
REQ-021 Read and write channels SHALL be independent; read accepted same cycle as a commit to same reg SHALL return pre-write value.
REQ-022 Minimum throughput: one write per 2 cycles, one read per 2 cycles, with BREADY/RREADY held high.
REQ-023 BRESP/RRESP SHALL be OKAY (2'b00) except per REQ-027.

Reset
REQ-024 On ARESET high at a clock edge: all regs 0, both FSMs idle, AWREADY/WREADY/ARREADY 0 in W_IDLE/R_IDLE-equivalent reset cycle, BVALID 0, RVALID 0, BRESP/RRESP/RDATA 0.
REQ-025 READY outputs SHALL be 0 while ARESET high and may assert the first cycle after release.
REQ-026 Reset mid-transaction SHALL abandon it: no commit, no response issued afterward.

Configuration
REQ-027 With AXIL_REG_SLVERR_EN defined: address with ADDR[1:0] != 0 SHALL return SLVERR (2'b10); write suppressed; read RDATA 0.
REQ-028 Without AXIL_REG_SLVERR_EN: ADDR[1:0] ignored, always OKAY.

Structure
REQ-029 Package axil_reg_pkg SHALL hold RESP_OKAY/RESP_SLVERR constants, NUM_REGS=4, write/read FSM state typedefs.
REQ-030 Byte-strobe merge SHALL be sub-module axil_strb_merge (old, new, strb -> merged); otherwise flat.

Verification
REQ-031 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC (AW,W simultaneous) -> BRESP OKAY each; reads return 0x1..0x4.
REQ-032 AW at cycle N, W at N+3 -> WREADY high N+1..N+3, commit at N+3, BVALID at N+4.
REQ-033 Reg 0x4=0xAABBCCDD, write 0x11223344 WSTRB=4'b0101 -> read 0xAA22CC44.
REQ-034 BREADY/RREADY low 5 cycles -> BVALID/RVALID, BRESP/RDATA stable; no new AW/AR accepted.
REQ-035 ARESET pulse during W_HAVE_AW after reg 0x8=0x3 -> regs_o all 0, no BVALID, next write works.
REQ-036 AXIL_REG_SLVERR_EN defined, write 0x5 to 0x2 -> BRESP SLVERR, regs unchanged; read 0x2 -> RRESP SLVERR, RDATA 0.

Source files
------------

// File: rtl/axil_reg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axil_reg_pkg                                                  |
// | Purpose  : Shared constants and FSM state types for the AXI4-Lite        |
// |            register responder (response codes, register count, write     |
// |            and read channel state encodings).                            |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package axil_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         NUM_REGS    = 4;
  localparam int         REG_IDX_W   = 2;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wstate_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

endpackage
`default_nettype wire

// File: rtl/axil_strb_merge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axil_strb_merge                                               |
// | Purpose  : Byte-lane merge: each output byte comes from i_new when its   |
// |            strobe bit is set, otherwise from i_old.                      |
// | Ports    : i_old    [DATA_WIDTH-1:0]   current register value            |
// |            i_new    [DATA_WIDTH-1:0]   incoming write data               |
// |            i_strb   [DATA_WIDTH/8-1:0] byte enables                      |
// |            o_merged [DATA_WIDTH-1:0]   merged result                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module axil_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   i_old,
  input  logic [DATA_WIDTH-1:0]   i_new,
  input  logic [DATA_WIDTH/8-1:0] i_strb,
  output logic [DATA_WIDTH-1:0]   o_merged
);

  for (genvar b = 0; b < DATA_WIDTH/8; b++) begin : g_byte
    assign o_merged[8*b +: 8] = i_strb[b] ? i_new[8*b +: 8] : i_old[8*b +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/axil_reg_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axil_reg_slave                                                |
// | Purpose  : AXI4-Lite responder with four 32-bit read/write registers,    |
// |            register index = ADDR[3:2]. Independent write and read FSMs.  |
// |            Optional macro AXIL_REG_SLVERR_EN: misaligned addresses       |
// |            (ADDR[1:0] != 0) get SLVERR, writes are dropped and reads     |
// |            return 0. Without it ADDR[1:0] is ignored.                    |
// | Ports    : ACLK, ARESET (sync, active-high)                              |
// |            S_AXI_AW*/W*/B* write address, data, response channels        |
// |            S_AXI_AR*/R*    read address and data channels                |
// |            regs_o [128]    live register contents, reg N at [32N+31:32N] |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH/8;
  localparam int AW     = C_S_AXI_ADDR_WIDTH;

  wstate_e             wstate_q, wstate_d;
  logic [AW-1:0]       awaddr_q, awaddr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [DW-1:0]       regs_d [NUM_REGS];

  rstate_e             rstate_q, rstate_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;

  logic                aw_hs, w_hs, ar_hs, commit;
  logic [AW-1:0]       commit_addr;
  logic [DW-1:0]       commit_data, merged;
  logic [STRB_W-1:0]   commit_strb;
  logic [REG_IDX_W-1:0] commit_idx, ar_idx;
  logic                commit_err, ar_err;

  // READY is gated by reset so nothing is offered while ARESET is held.
  assign S_AXI_AWREADY = ~ARESET & ((wstate_q == W_IDLE) || (wstate_q == W_HAVE_W));
  assign S_AXI_WREADY  = ~ARESET & ((wstate_q == W_IDLE) || (wstate_q == W_HAVE_AW));
  assign S_AXI_ARREADY = ~ARESET & (rstate_q == R_IDLE);
  assign S_AXI_BVALID  = (wstate_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (rstate_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // A write commits on the cycle its second half (AW or W) arrives; the
  // half that arrived earlier comes from the holding registers.
  assign commit = ((wstate_q == W_IDLE)    & aw_hs & w_hs) |
                  ((wstate_q == W_HAVE_AW) & w_hs) |
                  ((wstate_q == W_HAVE_W)  & aw_hs);
  assign commit_addr = (wstate_q == W_HAVE_AW) ? awaddr_q : S_AXI_AWADDR;
  assign commit_data = (wstate_q == W_HAVE_W)  ? wdata_q  : S_AXI_WDATA;
  assign commit_strb = (wstate_q == W_HAVE_W)  ? wstrb_q  : S_AXI_WSTRB;
  assign commit_idx  = commit_addr[REG_IDX_W+1:2];
  assign ar_idx      = S_AXI_ARADDR[REG_IDX_W+1:2];

`ifdef AXIL_REG_SLVERR_EN
  assign commit_err = |commit_addr[1:0];
  assign ar_err     = |S_AXI_ARADDR[1:0];
`else
  assign commit_err = 1'b0;
  assign ar_err     = 1'b0;
`endif

  axil_strb_merge #(.DATA_WIDTH(DW)) u_strb_merge (
    .i_old    (regs_q[commit_idx]),
    .i_new    (commit_data),
    .i_strb   (commit_strb),
    .o_merged (merged)
  );

  always_comb begin
    wstate_d = wstate_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    regs_d   = regs_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wstate_d = W_RESP;
        end else if (aw_hs) begin
          awaddr_d = S_AXI_AWADDR;
          wstate_d = W_HAVE_AW;
        end else if (w_hs) begin
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
          wstate_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_hs)         wstate_d = W_RESP;
      W_HAVE_W:  if (aw_hs)        wstate_d = W_RESP;
      W_RESP:    if (S_AXI_BREADY) wstate_d = W_IDLE;
      default:                     wstate_d = W_IDLE;
    endcase
    if (commit) begin
      bresp_d = commit_err ? RESP_SLVERR : RESP_OKAY;
      if (!commit_err) regs_d[commit_idx] = merged;
    end
  end

  // Reads sample regs_q, so a read accepted alongside a commit sees the old value.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: if (ar_hs) begin
        rstate_d = R_DATA;
        rdata_d  = ar_err ? '0 : regs_q[ar_idx];
        rresp_d  = ar_err ? RESP_SLVERR : RESP_OKAY;
      end
      R_DATA:  if (S_AXI_RREADY) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wstate_q <= wstate_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      regs_q   <= regs_d;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_o
    assign regs_o[i*DW +: DW] = regs_q[i];
  end

  // Protection bits and address bits outside the register index are not decoded.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, awaddr_q};

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_axil_reg_slave                                             |
// | Purpose  : Self-checking bench for axil_reg_slave. Expected responses    |
// |            are pushed to scoreboard queues when a request is accepted    |
// |            and popped when the DUT presents BVALID/RVALID. Honours       |
// |            AXIL_REG_SLVERR_EN in its reference model.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_axil_reg_slave;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [3:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [3:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [127:0] regs_o;

  axil_reg_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .regs_o(regs_o)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_regs [4];
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  function automatic bit model_err(input logic [3:0] addr);
`ifdef AXIL_REG_SLVERR_EN
    return addr[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [127:0] model_flat();
    return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  task automatic model_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    bq.push_back(model_err(addr) ? 2'b10 : 2'b00);
    if (!model_err(addr)) model_regs[addr[3:2]] = merge(model_regs[addr[3:2]], data, strb);
  endtask

  task automatic write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                       input int w_delay, input int b_hold);
    bit aw_done = 0, w_done = 0, aw_rdy, w_rdy;
    int cyc = 0;
    logic [1:0] exp;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_BREADY = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      S_AXI_AWVALID = !aw_done;
      S_AXI_WVALID  = !w_done && (cyc >= w_delay);
      if (aw_done && !w_done) begin
        check("wready_wait", S_AXI_WREADY, 1'b1);
        check("awready_wait", S_AXI_AWREADY, 1'b0);
      end
      aw_rdy = S_AXI_AWVALID && S_AXI_AWREADY;
      w_rdy  = S_AXI_WVALID && S_AXI_WREADY;
      step();
      cyc++;
      if (aw_rdy) aw_done = 1;
      if (w_rdy)  w_done  = 1;
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    if (!(aw_done && w_done)) begin
      check("write_hs_timeout", 1'b0, 1'b1);
    end else begin
      model_write(addr, data, strb);
      check("bvalid_lat", S_AXI_BVALID, 1'b1);
      check("regs_o", regs_o, model_flat());
      for (int i = 0; i < b_hold; i++) begin
        check("bvalid_hold", S_AXI_BVALID, 1'b1);
        check("bresp_stable", S_AXI_BRESP, bq[0]);
        check("awready_in_resp", S_AXI_AWREADY, 1'b0);
        step();
      end
      S_AXI_BREADY = 1;
      exp = bq.pop_front();
      check("bresp", S_AXI_BRESP, exp);
      step();
      S_AXI_BREADY = 0;
      check("bvalid_clr", S_AXI_BVALID, 1'b0);
    end
  endtask

  task automatic read(input logic [3:0] addr, input int r_hold);
    bit done = 0, rdy;
    int cyc = 0;
    logic [33:0] exp;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
    while (!done && cyc < 50) begin
      rdy = S_AXI_ARREADY;
      step();
      cyc++;
      if (rdy) done = 1;
    end
    S_AXI_ARVALID = 0;
    if (!done) begin
      check("read_hs_timeout", 1'b0, 1'b1);
    end else begin
      rq.push_back({model_err(addr) ? 2'b10 : 2'b00,
                    model_err(addr) ? 32'h0 : model_regs[addr[3:2]]});
      check("rvalid_lat", S_AXI_RVALID, 1'b1);
      for (int i = 0; i < r_hold; i++) begin
        check("rvalid_hold", S_AXI_RVALID, 1'b1);
        check("rdata_stable", S_AXI_RDATA, rq[0][31:0]);
        check("arready_in_data", S_AXI_ARREADY, 1'b0);
        step();
      end
      S_AXI_RREADY = 1;
      exp = rq.pop_front();
      check("rdata", S_AXI_RDATA, exp[31:0]);
      check("rresp", S_AXI_RRESP, exp[33:32]);
      step();
      S_AXI_RREADY = 0;
      check("rvalid_clr", S_AXI_RVALID, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [33:0] rexp;
    logic [1:0]  bexp;
    logic [3:0]  a;
    logic [31:0] d;
    ARESET = 1;
    S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;

    // Reset state
    step(); step();
    check("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    check("rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    check("rst_resp_data", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 36'h0);
    check("rst_regs", regs_o, 128'h0);
    ARESET = 0;
    #1;
    check("post_rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    // Four simultaneous AW/W writes, then read back
    for (int i = 0; i < 4; i++) write(4'(i*4), 32'(i+1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) read(4'(i*4), 0);

    // W arriving three cycles after AW
    write(4'h0, 32'hDEAD_0000, 4'hF, 3, 0);
    read(4'h0, 0);

    // Byte strobes
    write(4'h4, 32'hAABB_CCDD, 4'hF, 0, 0);
    write(4'h4, 32'h1122_3344, 4'b0101, 0, 0);
    read(4'h4, 0);

    // Back-pressure on B and R
    write(4'h8, 32'h1234_5678, 4'hF, 0, 5);
    read(4'h8, 5);

    // Read accepted in the same cycle as a commit to the same register
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 4'h4; S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
    check("coll_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    step();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    rq.push_back({2'b00, model_regs[1]});
    model_write(4'h4, 32'hCAFE_F00D, 4'hF);
    check("coll_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
    rexp = rq.pop_front();
    bexp = bq.pop_front();
    check("coll_rdata", S_AXI_RDATA, rexp[31:0]);
    check("coll_bresp", S_AXI_BRESP, bexp);
    check("coll_regs", regs_o, model_flat());
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    step();
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;

    // Random traffic
    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom_range(0, 3) * 4);
      d = $urandom;
      write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2));
      read(a, $urandom_range(0, 2));
    end

    // Misaligned address (SLVERR when enabled, otherwise treated as aligned)
    write(4'h2, 32'h5, 4'hF, 0, 0);
    check("misalign_regs", regs_o, model_flat());
    read(4'h2, 0);

    // Reset in W_HAVE_AW abandons the write
    write(4'h8, 32'h3, 4'hF, 0, 0);
    S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1;
    check("aw_only_ready", S_AXI_AWREADY, 1'b1);
    step();
    S_AXI_AWVALID = 0;
    ARESET = 1;
    #1;
    check("ready_in_rst", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    step();
    ARESET = 0;
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
    bq.delete();
    check("mid_rst_regs", regs_o, model_flat());
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_no_bvalid", S_AXI_BVALID, 1'b0);
      step();
    end
    write(4'hC, 32'h55AA_55AA, 4'hF, 0, 0);
    read(4'hC, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
